light_hash_ctrl: RTL

Sequencer that drives one light_hash core from a byte-stream requester.
- Frames each incoming message as head command, one message command per byte, then tail command.
- Paces every command against the core's busy flag.
- Captures the 64-bit digest and returns it over a valid/ready result port with byte count and error flag.
- Sits between the message source (DMA/UART byte FIFO) and light_hash; only block that writes the core's command inputs.

---
 rtl/light_hash_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/light_hash_ctrl.sv
// light_hash_ctrl: frames a byte stream into head/message/tail commands for one light_hash core
// Ports: in_* byte-stream sink (valid/ready, last, empty); lh_* core command outputs and
// busy/digest inputs; dig_* result source (valid/ready, 64-bit digest, byte count, error).
module light_hash_ctrl #(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_byte,
    input  logic             in_last,
    input  logic             in_empty,
    output logic [7:0]       lh_message_byte,
    output logic             lh_message_valid,
    output logic [1:0]       lh_state,
    input  logic             lh_busy,
    input  logic [63:0]      lh_digest,
    input  logic             lh_digest_ready,
    output logic             dig_valid,
    input  logic             dig_ready,
    output logic [63:0]      dig_data,
    output logic [LEN_W-1:0] dig_len,
    output logic             dig_err
);
    typedef enum logic [3:0] {
        IDLE, HEAD, HEAD_WAIT, FETCH, BYTE, BYTE_WAIT, TAIL, TAIL_WAIT, OUT, DRAIN
    } state_t;

    localparam logic [9:0] WD_MAX = 10'(TIMEOUT);

    state_t           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             last_q, last_d;
    logic             drain_q, drain_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [9:0]       wd_q, wd_d;
    logic [63:0]      dig_data_q, dig_data_d;
    logic [LEN_W-1:0] dig_len_q, dig_len_d;
    logic             dig_err_q, dig_err_d;
    logic             wait_st, wait_done, expired, take;

    assign wait_st   = state_q inside {HEAD_WAIT, BYTE_WAIT, TAIL_WAIT};
    // wd_q is zero only in the first cycle of a wait, where busy may still lag the pulse
    assign wait_done = (wd_q != '0) && !lh_busy && (state_q != TAIL_WAIT || lh_digest_ready);
    assign expired   = wd_q >= WD_MAX;
    assign take      = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            byte_q     <= '0;
            last_q     <= 1'b0;
            drain_q    <= 1'b0;
            cnt_q      <= '0;
            wd_q       <= '0;
            dig_data_q <= '0;
            dig_len_q  <= '0;
            dig_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            last_q     <= last_d;
            drain_q    <= drain_d;
            cnt_q      <= cnt_d;
            wd_q       <= wd_d;
            dig_data_q <= dig_data_d;
            dig_len_q  <= dig_len_d;
            dig_err_q  <= dig_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        last_d     = last_q;
        drain_d    = drain_q;
        cnt_d      = cnt_q;
        dig_data_d = dig_data_q;
        dig_len_d  = dig_len_q;
        dig_err_d  = dig_err_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // a core left busy by a reset must finish before a new head is issued
                if (in_valid && !lh_busy) state_d = HEAD;
            end
            HEAD:      state_d = HEAD_WAIT;
            HEAD_WAIT: if (wait_done) state_d = FETCH;
            FETCH: if (take) begin
                last_d = in_last;
                if (in_last && in_empty) state_d = TAIL;
                else begin
                    state_d = BYTE;
                    byte_d  = in_byte;
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                end
            end
            BYTE:      state_d = BYTE_WAIT;
            BYTE_WAIT: if (wait_done) state_d = last_q ? TAIL : FETCH;
            TAIL:      state_d = TAIL_WAIT;
            TAIL_WAIT: if (wait_done) begin
                state_d    = OUT;
                dig_data_d = lh_digest;
                dig_len_d  = cnt_q;
                dig_err_d  = 1'b0;
                drain_d    = 1'b0;
            end
            OUT:   if (dig_ready) state_d = drain_q ? DRAIN : IDLE;
            DRAIN: if (take && in_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (wait_st && !wait_done && expired) begin
            state_d    = OUT;
            dig_data_d = '0;
            dig_len_d  = cnt_q;
            dig_err_d  = 1'b1;
            // the requester still owes bytes up to in_last unless the last one was taken
            drain_d    = (state_q == HEAD_WAIT) || (state_q == BYTE_WAIT && !last_q);
        end
    end

    assign wd_d = (wait_st && state_d == state_q) ? wd_q + 1'b1 : '0;

    always_comb begin
        in_ready         = state_q == FETCH || state_q == DRAIN;
        lh_message_valid = state_q inside {HEAD, BYTE, TAIL};
        lh_state         = state_q == HEAD ? 2'b00 : state_q == BYTE ? 2'b10 :
                           state_q == TAIL ? 2'b01 : 2'b11;
        dig_valid        = state_q == OUT;
    end

    assign lh_message_byte = byte_q;
    assign dig_data        = dig_data_q;
    assign dig_len         = dig_len_q;
    assign dig_err         = dig_err_q;
endmodule
